cdb_req_buffer: RTL and testbench
=================================

# cdb_req_buffer

Per-functional-unit result buffer that sits between one execution unit and the CDB arbiter, forming the requester side of the CDB request/grant handshake. Completed results (tag + value) are queued in a small in-order FIFO; while non-empty, the buffer raises its CDB request bit. On a grant, it drives the head entry onto the CDB and retires it. It back-pressures the functional unit when full and discards all contents on a pipeline flush.

## Interface
Parameters:
- DEPTH, 4, number of result entries; power of two, at least 2
- TAG_W, 4, width of the destination/ROB tag
- DATA_W, 32, width of the result value

Ports:
- clk  input  1  core clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-low
- stall_i  input  1  global pipeline stall; while high, no entry retires
- flush_i  input  1  synchronous flush; discards all entries
- fu_valid_i  input  1  functional unit presents a completed result
- fu_tag_i  input  TAG_W  result tag
- fu_data_i  input  DATA_W  result value
- fu_ready_o  output  1  buffer accepts a result this cycle
- cdb_req_o  output  1  request bit to the CDB arbiter
- cdb_grant_i  input  1  this unit's grant bit from the arbiter, combinational in the same cycle
- cdb_valid_o  output  1  head entry is on the CDB this cycle
- cdb_tag_o  output  TAG_W  head tag; 0 when cdb_valid_o is low
- cdb_data_o  output  DATA_W  head value; 0 when cdb_valid_o is low
- count_o  output  log2(DEPTH)+1  number of occupied entries

## Operation
Storage:
- Circular register array with rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- count register ranges 0..DEPTH.
- empty = (count == 0); full = (count == DEPTH).

Push:
- push = fu_valid_i & fu_ready_o & !flush_i.
- Writes {tag, data} at wr_ptr and increments wr_ptr.
- fu_valid_i while fu_ready_o is low is ignored. The FU must hold its result.

Request and grant:
- cdb_req_o = !empty. It depends on registered state only and has no bypass from fu_valid_i.
- pop = cdb_grant_i & !empty & !stall_i & !flush_i.
- cdb_valid_o = pop. cdb_tag_o and cdb_data_o show the head entry when pop is high, else 0.
- On pop, rd_ptr increments.
- A grant while empty is ignored; outputs stay 0.

Count update per cycle:
- push only: +1.
- pop only: -1.
- both: unchanged.
- Push and pop in the same cycle on a non-full buffer is legal, including count == 1. In that case the old head leaves and the new entry is written at wr_ptr.

Back-pressure:
- fu_ready_o = !full. It is computed from registered count, so a pop in the same cycle does not free a slot until the next cycle.

Stall:
- Pushes continue.
- Pops are blocked and cdb_req_o stays asserted, which matches the arbiter holding its grant state under stall.

Flush:
- Sets rd_ptr = wr_ptr = 0 and count = 0 next cycle.
- Overrides push and pop in the same cycle.
- cdb_valid_o is 0 in the flush cycle.

Reset (rst low at a clock edge):
- Pointers and count are 0, so cdb_req_o = 0, cdb_valid_o = 0, cdb_tag_o/cdb_data_o = 0, fu_ready_o = 1, count_o = 0.
- Reset mid-operation discards all entries identically to flush.
- Entry storage need not be reset.

## Timing
- Push-to-request latency: 1 cycle. A result accepted at edge N raises cdb_req_o after edge N.
- Request-to-broadcast: 0 cycles beyond the grant. The head is driven combinationally in the grant cycle and retired at the following edge.
- Minimum result latency (FU to CDB): 1 cycle.
- Steady-state throughput with continuous grants: 1 result per cycle.
- Results leave strictly in acceptance order.
- No combinational path from fu_valid_i to cdb_req_o, cdb_valid_o or fu_ready_o.
- There is a combinational path from cdb_grant_i and stall_i to cdb_valid_o and the CDB outputs.

## Test plan
- Reset behaviour: hold rst low 2 cycles with fu_valid_i = 1 and cdb_grant_i = 1 -> cdb_req_o = 0, cdb_valid_o = 0, fu_ready_o = 1 and count_o = 0 throughout; nothing is accepted.
- Single result: push tag 3 / data 0xDEADBEEF at cycle 0 -> cdb_req_o = 1 in cycle 1; grant in cycle 2 -> cdb_valid_o = 1 with tag 3 / 0xDEADBEEF in cycle 2; cdb_req_o = 0 and count_o = 0 in cycle 3.
- Fill to full: push 4 results (tags 1-4) with no grant -> fu_ready_o = 0 and count_o = 4. A fifth fu_valid_i is ignored. Then grant 4 cycles -> tags 1, 2, 3, 4 in order, and fu_ready_o = 1 the cycle after the first pop.
- Simultaneous push/pop with wrap: keep count at 1, then push and grant every cycle for 10 cycles -> count_o stays 1; output tags equal input tags delayed 1 cycle, across pointer wrap.
- Stall: 2 entries, grant held, stall_i = 1 for 3 cycles -> cdb_valid_o = 0, cdb_req_o = 1 and count_o = 2 throughout. After stall drops, the entries retire in order on consecutive cycles.
- Flush and empty grant: 3 entries; assert flush_i together with fu_valid_i and grant -> cdb_valid_o = 0 that cycle and count_o = 0 next cycle. A following grant while empty gives cdb_valid_o = 0 and zero outputs.

Source files
------------

// File: rtl/cdb_req_buffer_if.sv
// Signal bundle between one functional unit, the CDB arbiter and its result buffer.
// The buffer connects as slave; the FU/arbiter side (or a bench) connects as master.
interface cdb_req_buffer_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned DATA_W = 32
);
   logic                     stall_i;
   logic                     flush_i;
   logic                     fu_valid_i;
   logic [TAG_W-1:0]         fu_tag_i;
   logic [DATA_W-1:0]        fu_data_i;
   logic                     fu_ready_o;
   logic                     cdb_req_o;
   logic                     cdb_grant_i;
   logic                     cdb_valid_o;
   logic [TAG_W-1:0]         cdb_tag_o;
   logic [DATA_W-1:0]        cdb_data_o;
   logic [$clog2(DEPTH):0]   count_o;

   modport slave (
      input  stall_i, flush_i, fu_valid_i, fu_tag_i, fu_data_i, cdb_grant_i,
      output fu_ready_o, cdb_req_o, cdb_valid_o, cdb_tag_o, cdb_data_o, count_o
   );

   modport master (
      output stall_i, flush_i, fu_valid_i, fu_tag_i, fu_data_i, cdb_grant_i,
      input  fu_ready_o, cdb_req_o, cdb_valid_o, cdb_tag_o, cdb_data_o, count_o
   );
endinterface

// File: rtl/cdb_req_buffer.sv
// In-order result FIFO between one functional unit and the CDB arbiter: requests
// while non-empty, broadcasts the head combinationally in its grant cycle.
module cdb_req_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned DATA_W = 32
) (
   input logic               clk,
   input logic               rst,
   cdb_req_buffer_if.slave   bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W:0]    count;

   logic empty;
   logic full;
   logic push;
   logic pop;

   assign empty = (count == '0);
   assign full  = (count == (PTR_W+1)'(DEPTH));

   // Ready and request come from registered count only, so neither sees fu_valid_i.
   assign bus.fu_ready_o = !full;
   assign bus.cdb_req_o  = !empty;
   assign bus.count_o    = count;

   assign push = bus.fu_valid_i & !full & !bus.flush_i;
   assign pop  = bus.cdb_grant_i & !empty & !bus.stall_i & !bus.flush_i;

   assign bus.cdb_valid_o = pop;
   assign bus.cdb_tag_o   = pop ? tag_mem[rd_ptr]  : '0;
   assign bus.cdb_data_o  = pop ? data_mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst || bus.flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is left unreset; only the pointers/count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr]  <= bus.fu_tag_i;
         data_mem[wr_ptr] <= bus.fu_data_i;
      end
   end
endmodule

// File: tb/tb_cdb_req_buffer.sv
// Directed bench for cdb_req_buffer: reset, single result, fill/drain, push+pop
// across pointer wrap, stall and flush, with hand-computed expectations.
module tb_cdb_req_buffer;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned TAG_W  = 4;
   localparam int unsigned DATA_W = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   cdb_req_buffer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   cdb_req_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic valid, input logic [TAG_W-1:0] tag,
                        input logic [DATA_W-1:0] data, input logic grant,
                        input logic stall, input logic flush);
      bus.fu_valid_i  = valid;
      bus.fu_tag_i    = tag;
      bus.fu_data_i   = data;
      bus.cdb_grant_i = grant;
      bus.stall_i     = stall;
      bus.flush_i     = flush;
      #2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      step();

      // Reset held with valid and grant high: nothing may be accepted.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 4'h5, 32'h5555_5555, 1'b1, 1'b0, 1'b0);
         check("rst_req",   bus.cdb_req_o,   0);
         check("rst_valid", bus.cdb_valid_o, 0);
         check("rst_ready", bus.fu_ready_o,  1);
         check("rst_count", bus.count_o,     0);
         check("rst_tag",   bus.cdb_tag_o,   0);
         step();
      end
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("rst_after_count", bus.count_o,   0);
      check("rst_after_req",   bus.cdb_req_o, 0);

      // Single result.
      drive(1'b1, 4'h3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      check("single_c0_req", bus.cdb_req_o, 0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("single_c1_req",   bus.cdb_req_o,   1);
      check("single_c1_count", bus.count_o,     1);
      check("single_c1_valid", bus.cdb_valid_o, 0);
      step();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check("single_c2_valid", bus.cdb_valid_o, 1);
      check("single_c2_tag",   bus.cdb_tag_o,   4'h3);
      check("single_c2_data",  bus.cdb_data_o,  32'hDEAD_BEEF);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("single_c3_req",   bus.cdb_req_o, 0);
      check("single_c3_count", bus.count_o,   0);

      // Fill to full, then an ignored fifth push, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, TAG_W'(i), 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
         check("fill_ready", bus.fu_ready_o, 1);
         step();
      end
      drive(1'b1, 4'h9, 32'h999, 1'b0, 1'b0, 1'b0);
      check("full_ready", bus.fu_ready_o, 0);
      check("full_count", bus.count_o,    4);
      step();
      check("full_ignored_count", bus.count_o, 4);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
         check("drain_valid", bus.cdb_valid_o, 1);
         check("drain_tag",   bus.cdb_tag_o,   i);
         check("drain_data",  bus.cdb_data_o,  32'h100 + 32'(i));
         if (i == 1) check("drain_ready_same", bus.fu_ready_o, 0);
         if (i == 2) check("drain_ready_next", bus.fu_ready_o, 1);
         step();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("drain_count", bus.count_o, 0);

      // Keep one entry, then push+grant every cycle across pointer wraps.
      drive(1'b1, 4'hA, 32'hA0, 1'b0, 1'b0, 1'b0);
      step();
      for (int k = 0; k < 10; k++) begin
         logic [TAG_W-1:0]  exp_tag;
         logic [DATA_W-1:0] exp_data;
         exp_tag  = (k == 0) ? 4'hA  : TAG_W'(k - 1);
         exp_data = (k == 0) ? 32'hA0 : 32'h200 + 32'(k - 1);
         drive(1'b1, TAG_W'(k), 32'h200 + 32'(k), 1'b1, 1'b0, 1'b0);
         check("wrap_count", bus.count_o,     1);
         check("wrap_valid", bus.cdb_valid_o, 1);
         check("wrap_tag",   bus.cdb_tag_o,   exp_tag);
         check("wrap_data",  bus.cdb_data_o,  exp_data);
         step();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check("wrap_last_tag", bus.cdb_tag_o, 4'h9);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("wrap_end_count", bus.count_o, 0);

      // Stall with grant held blocks retirement.
      drive(1'b1, 4'h5, 32'h55, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 4'h6, 32'h66, 1'b0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
         check("stall_valid", bus.cdb_valid_o, 0);
         check("stall_req",   bus.cdb_req_o,   1);
         check("stall_count", bus.count_o,     2);
         check("stall_tag",   bus.cdb_tag_o,   0);
         step();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check("unstall_tag0", bus.cdb_tag_o,  4'h5);
      check("unstall_dat0", bus.cdb_data_o, 32'h55);
      step();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check("unstall_tag1", bus.cdb_tag_o,  4'h6);
      check("unstall_dat1", bus.cdb_data_o, 32'h66);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("unstall_count", bus.count_o, 0);

      // Flush with push and grant in the same cycle, then a grant while empty.
      for (int i = 7; i <= 9; i++) begin
         drive(1'b1, TAG_W'(i), 32'(i), 1'b0, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("preflush_count", bus.count_o, 3);
      drive(1'b1, 4'hF, 32'hFFFF, 1'b1, 1'b0, 1'b1);
      check("flush_valid", bus.cdb_valid_o, 0);
      check("flush_tag",   bus.cdb_tag_o,   0);
      step();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check("flush_count",   bus.count_o,     0);
      check("flush_req",     bus.cdb_req_o,   0);
      check("empty_valid",   bus.cdb_valid_o, 0);
      check("empty_tag",     bus.cdb_tag_o,   0);
      check("empty_data",    bus.cdb_data_o,  0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("empty_count", bus.count_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
